// File: rtl/dfii_csr_responder_pkg.sv
// ============================================================================
// Module  : dfii_csr_responder_pkg
// Brief   : Register offsets, field indices and handshake states for DFII CSRs
// Revision: 1.0
// ============================================================================
`default_nettype none

package dfii_csr_responder_pkg;

    localparam int unsigned c_WINDOW_WORDS = 16;

    localparam logic [3:0] c_OFF_CONTROL  = 4'd0;
    localparam logic [3:0] c_OFF_COMMAND  = 4'd1;
    localparam logic [3:0] c_OFF_ISSUE    = 4'd2;
    localparam logic [3:0] c_OFF_ADDRESS  = 4'd3;
    localparam logic [3:0] c_OFF_BADDRESS = 4'd4;
    localparam logic [3:0] c_OFF_WRDATA   = 4'd5;
    localparam logic [3:0] c_OFF_RDDATA   = 4'd6;

    localparam int c_CONTROL_BITS = 4;
    localparam int c_CTL_SEL      = 0;
    localparam int c_CTL_CKE      = 1;
    localparam int c_CTL_ODT      = 2;
    localparam int c_CTL_RESET_N  = 3;

    localparam int c_COMMAND_BITS = 6;
    localparam int c_CMD_CS       = 0;
    localparam int c_CMD_WE       = 1;
    localparam int c_CMD_CAS      = 2;
    localparam int c_CMD_RAS      = 3;
    localparam int c_CMD_WREN     = 4;
    localparam int c_CMD_RDEN     = 5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } ack_state_t;

    // Replace only the byte lanes enabled in sel.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_csr_ack_fsm.sv
// ============================================================================
// Module  : wb_csr_ack_fsm
// Brief   : 16-word CSR window decode and single-cycle Wishbone ack handshake
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_csr_ack_fsm
    import dfii_csr_responder_pkg::*;
#(
    parameter int unsigned BASE_WORD_ADR = 32'h2400,
    parameter int          WB_ADR_WIDTH  = 30
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WB_ADR_WIDTH-1:0] i_adr,
    input  logic                    i_cyc,
    input  logic                    i_stb,
    input  logic                    i_we,
    output logic                    o_ack,
    output logic                    o_wr_en,
    output logic                    o_rd_en,
    output logic [3:0]              o_offset
);

    ack_state_t              r_state;
    ack_state_t              w_state_nxt;
    logic [WB_ADR_WIDTH-1:0] w_rel;
    logic                    w_hit;
    logic                    w_req;

    // Subtract-then-compare catches addresses below the base via wraparound.
    assign w_rel = i_adr - WB_ADR_WIDTH'(BASE_WORD_ADR);
    assign w_hit = (w_rel < WB_ADR_WIDTH'(c_WINDOW_WORDS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req = i_cyc & i_stb & w_hit;
                if (w_req) w_state_nxt = ST_ACK;
            end
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_ack    = (r_state == ST_ACK);
    assign o_wr_en  = w_req & i_we;
    assign o_rd_en  = w_req & ~i_we;
    assign o_offset = w_rel[3:0];

endmodule

`default_nettype wire

// File: rtl/dfii_csr_responder.sv
// ============================================================================
// Module  : dfii_csr_responder
// Brief   : Wishbone CSR bank giving software direct control of the DFI port
// Revision: 1.0
// ============================================================================
`default_nettype none

module dfii_csr_responder
    import dfii_csr_responder_pkg::*;
#(
    parameter int unsigned BASE_WORD_ADR  = 32'h2400,
    parameter int          ADDR_BITS      = 14,
    parameter int          BANK_BITS      = 3,
    parameter int          DFI_DATA_WIDTH = 32,
    parameter int          WB_ADR_WIDTH   = 30
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WB_ADR_WIDTH-1:0]   wb_adr,
    input  logic [31:0]               wb_dat_w,
    output logic [31:0]               wb_dat_r,
    input  logic [3:0]                wb_sel,
    input  logic                      wb_cyc,
    input  logic                      wb_stb,
    input  logic                      wb_we,
    output logic                      wb_ack,
    output logic                      dfi_sel,
    output logic                      dfi_cke,
    output logic                      dfi_odt,
    output logic                      dfi_reset_n,
    output logic                      dfi_cs_n,
    output logic                      dfi_ras_n,
    output logic                      dfi_cas_n,
    output logic                      dfi_we_n,
    output logic [ADDR_BITS-1:0]      dfi_address,
    output logic [BANK_BITS-1:0]      dfi_bank,
    output logic                      dfi_wrdata_en,
    output logic                      dfi_rddata_en,
    output logic [DFI_DATA_WIDTH-1:0] dfi_wrdata,
    input  logic [DFI_DATA_WIDTH-1:0] dfi_rddata,
    input  logic                      dfi_rddata_valid
);

    logic                      w_wr_en;
    logic                      w_rd_en;
    logic [3:0]                w_offset;
    logic [31:0]               w_addr_m;
    logic [31:0]               w_bank_m;
    logic [31:0]               w_wrd_m;
    logic [31:0]               w_rd_mux;

    logic [c_CONTROL_BITS-1:0] r_control;
    logic [c_COMMAND_BITS-1:0] r_command;
    logic [ADDR_BITS-1:0]      r_address;
    logic [BANK_BITS-1:0]      r_baddress;
    logic [DFI_DATA_WIDTH-1:0] r_wrdata;
    logic [DFI_DATA_WIDTH-1:0] r_rddata;
    logic [31:0]               r_dat_r;
    logic                      r_issue;

    wb_csr_ack_fsm #(
        .BASE_WORD_ADR (BASE_WORD_ADR),
        .WB_ADR_WIDTH  (WB_ADR_WIDTH)
    ) u_ack_fsm (
        .clk      (clk),
        .rst      (rst),
        .i_adr    (wb_adr),
        .i_cyc    (wb_cyc),
        .i_stb    (wb_stb),
        .i_we     (wb_we),
        .o_ack    (wb_ack),
        .o_wr_en  (w_wr_en),
        .o_rd_en  (w_rd_en),
        .o_offset (w_offset)
    );

    assign w_addr_m = byte_merge(32'(r_address),  wb_dat_w, wb_sel);
    assign w_bank_m = byte_merge(32'(r_baddress), wb_dat_w, wb_sel);
    assign w_wrd_m  = byte_merge(32'(r_wrdata),   wb_dat_w, wb_sel);

    always_comb begin
        w_rd_mux = 32'd0;
        case (w_offset)
            c_OFF_CONTROL:  w_rd_mux = 32'(r_control);
            c_OFF_COMMAND:  w_rd_mux = 32'(r_command);
            c_OFF_ADDRESS:  w_rd_mux = 32'(r_address);
            c_OFF_BADDRESS: w_rd_mux = 32'(r_baddress);
            c_OFF_WRDATA:   w_rd_mux = 32'(r_wrdata);
            c_OFF_RDDATA:   w_rd_mux = 32'(r_rddata);
            default:        w_rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_control  <= '0;
            r_command  <= '0;
            r_address  <= '0;
            r_baddress <= '0;
            r_wrdata   <= '0;
            r_rddata   <= '0;
            r_dat_r    <= '0;
            r_issue    <= 1'b0;
        end else begin
            r_issue <= 1'b0;
            if (w_wr_en) begin
                case (w_offset)
                    c_OFF_CONTROL:  if (wb_sel[0]) r_control <= wb_dat_w[c_CONTROL_BITS-1:0];
                    c_OFF_COMMAND:  if (wb_sel[0]) r_command <= wb_dat_w[c_COMMAND_BITS-1:0];
                    c_OFF_ISSUE:    r_issue    <= wb_sel[0] & wb_dat_w[0];
                    c_OFF_ADDRESS:  r_address  <= w_addr_m[ADDR_BITS-1:0];
                    c_OFF_BADDRESS: r_baddress <= w_bank_m[BANK_BITS-1:0];
                    c_OFF_WRDATA:   r_wrdata   <= w_wrd_m[DFI_DATA_WIDTH-1:0];
                    default: ;
                endcase
            end
            // The read mux sees the old RDDATA, so a same-edge capture is not visible yet.
            if (w_rd_en)          r_dat_r  <= w_rd_mux;
            if (dfi_rddata_valid) r_rddata <= dfi_rddata;
        end
    end

    assign wb_dat_r      = r_dat_r;

    assign dfi_sel       = r_control[c_CTL_SEL];
    assign dfi_cke       = r_control[c_CTL_CKE];
    assign dfi_odt       = r_control[c_CTL_ODT];
    assign dfi_reset_n   = r_control[c_CTL_RESET_N];

    assign dfi_cs_n      = ~(r_issue & r_command[c_CMD_CS]);
    assign dfi_ras_n     = ~(r_issue & r_command[c_CMD_RAS]);
    assign dfi_cas_n     = ~(r_issue & r_command[c_CMD_CAS]);
    assign dfi_we_n      = ~(r_issue & r_command[c_CMD_WE]);
    assign dfi_wrdata_en = r_issue & r_command[c_CMD_WREN];
    assign dfi_rddata_en = r_issue & r_command[c_CMD_RDEN];

    assign dfi_address   = r_address;
    assign dfi_bank      = r_baddress;
    assign dfi_wrdata    = r_wrdata;

endmodule

`default_nettype wire

// File: tb/tb_dfii_csr_responder.sv
// ============================================================================
// Module  : tb_dfii_csr_responder
// Brief   : Self-checking bench for dfii_csr_responder against a register model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dfii_csr_responder;

    localparam int BASE = 32'h2400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [29:0] wb_adr = '0;
    logic [31:0] wb_dat_w = '0;
    logic [31:0] wb_dat_r;
    logic [3:0]  wb_sel = '0;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_we = 1'b0;
    logic        wb_ack;
    logic        dfi_sel, dfi_cke, dfi_odt, dfi_reset_n;
    logic        dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n;
    logic [13:0] dfi_address;
    logic [2:0]  dfi_bank;
    logic        dfi_wrdata_en, dfi_rddata_en;
    logic [31:0] dfi_wrdata;
    logic [31:0] dfi_rddata;
    logic        dfi_rddata_valid;

    logic        rand_en = 1'b0;
    logic        rnd_valid = 1'b0;
    logic [31:0] rnd_data = '0;
    logic        dir_valid = 1'b0;
    logic [31:0] dir_data = '0;
    logic        chk_en = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    assign dfi_rddata       = rand_en ? rnd_data  : dir_data;
    assign dfi_rddata_valid = rand_en ? rnd_valid : dir_valid;

    always #5 clk = ~clk;

    dfii_csr_responder dut (
        .clk              (clk),
        .rst              (rst),
        .wb_adr           (wb_adr),
        .wb_dat_w         (wb_dat_w),
        .wb_dat_r         (wb_dat_r),
        .wb_sel           (wb_sel),
        .wb_cyc           (wb_cyc),
        .wb_stb           (wb_stb),
        .wb_we            (wb_we),
        .wb_ack           (wb_ack),
        .dfi_sel          (dfi_sel),
        .dfi_cke          (dfi_cke),
        .dfi_odt          (dfi_odt),
        .dfi_reset_n      (dfi_reset_n),
        .dfi_cs_n         (dfi_cs_n),
        .dfi_ras_n        (dfi_ras_n),
        .dfi_cas_n        (dfi_cas_n),
        .dfi_we_n         (dfi_we_n),
        .dfi_address      (dfi_address),
        .dfi_bank         (dfi_bank),
        .dfi_wrdata_en    (dfi_wrdata_en),
        .dfi_rddata_en    (dfi_rddata_en),
        .dfi_wrdata       (dfi_wrdata),
        .dfi_rddata       (dfi_rddata),
        .dfi_rddata_valid (dfi_rddata_valid)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Readable bits of each register as seen over Wishbone.
    function automatic logic [31:0] reg_mask(input int off);
        case (off)
            0:       return 32'h0000_000F;
            1:       return 32'h0000_003F;
            3:       return 32'h0000_3FFF;
            4:       return 32'h0000_0007;
            5:       return 32'hFFFF_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] m_reg [16];
    logic [31:0] m_rddata, m_datr;
    logic        m_ack, m_rd, m_pulse;

    always @(posedge clk) begin
        logic [31:0] rel;
        logic        req;
        int          off;
        if (rst) begin
            foreach (m_reg[i]) m_reg[i] = 32'h0;
            m_rddata = 0; m_datr = 0; m_ack = 0; m_rd = 0; m_pulse = 0;
        end else begin
            rel     = 32'(wb_adr) - 32'(BASE);
            req     = wb_cyc && wb_stb && !m_ack && (rel < 32'd16);
            m_pulse = 1'b0;
            if (req) begin
                off = int'(rel);
                if (wb_we) begin
                    if (off == 0 || off == 1) begin
                        if (wb_sel[0]) m_reg[off] = wb_dat_w & reg_mask(off);
                    end else if (off == 2) begin
                        m_pulse = wb_sel[0] && wb_dat_w[0];
                    end else begin
                        for (int b = 0; b < 4; b++)
                            if (wb_sel[b]) m_reg[off][8*b +: 8] = wb_dat_w[8*b +: 8];
                        m_reg[off] = m_reg[off] & reg_mask(off);
                    end
                end else begin
                    m_datr = (off == 6) ? m_rddata : m_reg[off];
                end
                m_rd = !wb_we;
            end
            if (dfi_rddata_valid) m_rddata = dfi_rddata;
            m_ack = req;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [3:0] e_cmdn;
        logic [1:0] e_en;
        if (chk_en) begin
            e_cmdn = m_pulse ? ~{m_reg[1][0], m_reg[1][3], m_reg[1][2], m_reg[1][1]} : 4'hF;
            e_en   = m_pulse ? m_reg[1][5:4] : 2'b00;
            chk("ack", 32'(wb_ack), 32'(m_ack));
            if (m_ack && m_rd) chk("dat_r", wb_dat_r, m_datr);
            chk("ctrl", 32'({dfi_reset_n, dfi_odt, dfi_cke, dfi_sel}), 32'(m_reg[0][3:0]));
            chk("cmd_n", 32'({dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n}), 32'(e_cmdn));
            chk("data_en", 32'({dfi_rddata_en, dfi_wrdata_en}), 32'(e_en));
            chk("address", 32'(dfi_address), m_reg[3]);
            chk("bank", 32'(dfi_bank), m_reg[4]);
            chk("wrdata", dfi_wrdata, m_reg[5]);
        end
    end

    always @(posedge clk) begin
        #1;
        rnd_valid = rand_en && ($urandom_range(0, 3) == 0);
        rnd_data  = $urandom;
    end

    // ---------------- bus tasks ----------------
    task automatic bus(input int off, input logic we, input logic [31:0] dat, input logic [3:0] sel,
                       output logic [31:0] rdat, output int lat, output logic [3:0] cmdn);
        wb_adr = 30'(BASE + off); wb_we = we; wb_dat_w = dat; wb_sel = sel;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        lat = 0; rdat = '0; cmdn = 4'hF;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (wb_ack) begin
                lat  = i;
                rdat = wb_dat_r;
                cmdn = {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n};
                break;
            end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input int off, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] d; int lat; logic [3:0] c;
        bus(off, 1'b1, dat, sel, d, lat, c);
        chk("wr_latency", 32'(lat), 32'd1);
    endtask

    task automatic rd(input int off, output logic [31:0] d);
        int lat; logic [3:0] c;
        bus(off, 1'b0, 32'h0, 4'hF, d, lat, c);
        chk("rd_latency", 32'(lat), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        logic [3:0]  c;
        int          lat, n;

        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_ack", 32'(wb_ack), 32'd0);
        chk("rst_reset_n", 32'(dfi_reset_n), 32'd0);
        chk("rst_cs_n", 32'(dfi_cs_n), 32'd1);
        for (int o = 0; o <= 6; o++) begin
            rd(o, d);
            chk("rst_read", d, 32'h0);
        end

        wr(0, 32'h0C, 4'hF);
        wr(0, 32'h0E, 4'hF);
        chk("ctrl_literal", 32'({dfi_odt, dfi_reset_n, dfi_cke, dfi_sel}), 32'b1110);

        wr(3, 32'h200, 4'hF);
        wr(4, 32'h2, 4'hF);
        wr(1, 32'h0F, 4'hF);
        bus(2, 1'b1, 32'h1, 4'hF, d, lat, c);
        chk("issue_cmd_n", 32'(c), 32'h0);
        chk("issue_addr", 32'(dfi_address), 32'h200);
        chk("issue_bank", 32'(dfi_bank), 32'h2);
        chk("issue_nop_after", 32'({dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n}), 32'hF);

        wr(3, 32'h400, 4'hF);
        wr(1, 32'h03, 4'hF);
        bus(2, 1'b1, 32'h1, 4'hF, d, lat, c);
        chk("zqcl_cmd_n", 32'(c), 32'b0110);
        bus(2, 1'b1, 32'h0, 4'hF, d, lat, c);
        chk("issue0_no_pulse", 32'(c), 32'hF);
        bus(2, 1'b1, 32'h1, 4'hE, d, lat, c);
        chk("issue_sel0_no_pulse", 32'(c), 32'hF);

        dir_data = 32'hFACECA8C; dir_valid = 1'b1;
        @(posedge clk); #1;
        dir_valid = 1'b0;
        rd(6, d);
        chk("rddata_capture", d, 32'hFACECA8C);

        wb_adr = 30'(BASE + 6); wb_we = 1'b0; wb_sel = 4'hF; wb_cyc = 1'b1; wb_stb = 1'b1;
        dir_data = 32'h12345678; dir_valid = 1'b1;
        @(posedge clk); #1;
        dir_valid = 1'b0;
        chk("same_edge_ack", 32'(wb_ack), 32'd1);
        chk("same_edge_old", wb_dat_r, 32'hFACECA8C);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(posedge clk); #1;
        rd(6, d);
        chk("rddata_new", d, 32'h12345678);

        wr(3, 32'h0, 4'hF);
        wr(3, 32'hFFFFFFFF, 4'h1);
        rd(3, d);
        chk("addr_bytelane", d, 32'h000000FF);

        bus(16, 1'b0, 32'h0, 4'hF, d, lat, c);
        chk("out_of_window_noack", 32'(lat), 32'd0);

        wb_adr = 30'(BASE + 5); wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (wb_ack) n++;
        end
        chk("held_stb_acks", 32'(n), 32'd3);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(posedge clk); #1;

        wb_adr = 30'(BASE + 2); wb_we = 1'b1; wb_dat_w = 32'h1; wb_sel = 4'hF;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_ack", 32'(wb_ack), 32'd1);
        rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_ack", 32'(wb_ack), 32'd0);
        chk("rst_mid_cmd", 32'({dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n}), 32'hF);
        chk("rst_mid_ctrl", 32'({dfi_reset_n, dfi_odt, dfi_cke, dfi_sel}), 32'h0);
        chk("rst_mid_addr", 32'(dfi_address), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        rand_en = 1'b1;
        for (int t = 0; t < 300; t++) begin
            int          off;
            logic        we;
            off = ($urandom_range(0, 15) == 0) ? $urandom_range(16, 19) : $urandom_range(0, 15);
            we  = $urandom_range(0, 1) == 1;
            bus(off, we, $urandom, 4'($urandom), d, lat, c);
            chk("rand_latency", 32'(lat), (off < 16) ? 32'd1 : 32'd0);
        end
        rand_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dfii_csr_responder.md
Name: dfii_csr_responder

Overview:
Wishbone classic responder that gives software direct control of the DRAM DFI interface. Decodes the 0x9000 CSR window (byte address), holds the control/command/address/data registers, and emits a single-cycle DFI command on each issue strobe. It sits between the SoC Wishbone crossbar and the DFI mux ahead of the PHY; its dfi_sel output hands the PHY to the hardware controller once initialisation is done.

Parameters:
BASE_WORD_ADR, 0x2400, word address of register 0 (byte 0x9000 >> 2); the window spans 16 words
ADDR_BITS, 14, DFI row/column address width
BANK_BITS, 3, DFI bank address width
DFI_DATA_WIDTH, 32, width of one DFI data phase
WB_ADR_WIDTH, 30, Wishbone word address width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
wb_adr  in  WB_ADR_WIDTH  word address
wb_dat_w  in  32  write data
wb_dat_r  out  32  read data, registered
wb_sel  in  4  byte lane enables
wb_cyc  in  1  cycle
wb_stb  in  1  strobe
wb_we  in  1  write enable
wb_ack  out  1  acknowledge
dfi_sel  out  1  1 = hardware controller owns DFI, 0 = this block
dfi_cke, dfi_odt, dfi_reset_n  out  1 each  static control levels
dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n  out  1 each  command, active low
dfi_address  out  ADDR_BITS  command address
dfi_bank  out  BANK_BITS  bank address
dfi_wrdata_en, dfi_rddata_en  out  1 each  data enables, pulsed with the command
dfi_wrdata  out  DFI_DATA_WIDTH  write data
dfi_rddata  in  DFI_DATA_WIDTH  read data
dfi_rddata_valid  in  1  read data qualifier

Behaviour:
- Register map (word offset from base):
  - 0 CONTROL: [0] sel, [1] cke, [2] odt, [3] reset_n.
  - 1 COMMAND: [0] cs, [1] we, [2] cas, [3] ras, [4] wrdata_en, [5] rddata_en.
  - 2 ISSUE: write-only strobe, reads 0.
  - 3 ADDRESS.
  - 4 BADDRESS.
  - 5 WRDATA.
  - 6 RDDATA: read-only.
  - 7-15: reserved, read 0, writes ignored.
- Reset: all registers 0; wb_ack=0; wb_dat_r=0; dfi_sel=0, cke=0, odt=0, reset_n=0. Command outputs idle at NOP: cs_n=ras_n=cas_n=we_n=1, wrdata_en=rddata_en=0. A reset mid-transaction drops ack and any pending issue pulse.
- Handshake FSM, states IDLE and ACK:
  - IDLE -> ACK when cyc&stb&!ack and adr is in [BASE_WORD_ADR, BASE_WORD_ADR+15]. The write or read capture happens on that same edge.
  - ACK: wb_ack=1 for exactly one cycle, then back to IDLE. Latency is one cycle from the sampled request to ack.
  - A master that holds stb through ack is served again starting the cycle after ack falls.
  - Out-of-window addresses never ack.
- Writes:
  - ADDRESS, BADDRESS and WRDATA honour wb_sel per byte.
  - CONTROL and COMMAND update only when sel[0]=1.
  - Fields are truncated to the register width; upper bits read 0.
- ISSUE write with dat_w[0]=1 and sel[0]=1: in the ACK cycle the DFI command outputs present the inverted COMMAND bits, ADDRESS, BADDRESS, and the enables. This lasts exactly one cycle, then outputs return to NOP.
  - Address, bank and wrdata hold their register values at all times.
  - dat_w[0]=0 produces no pulse.
- Control outputs (dfi_sel, cke, odt, reset_n) follow CONTROL bits combinationally from the register: they change the cycle after the write edge, coincident with ack.
- RDDATA captures dfi_rddata on every cycle dfi_rddata_valid=1, last value wins. A Wishbone read sampled on the same edge as a capture returns the pre-capture value.
- Command pulses are not gated by dfi_sel. The downstream mux discards them.

Decomposition:
- Shared package holds:
  - Register offsets.
  - CONTROL bit indices (SEL=0, CKE=1, ODT=2, RESET_N=3).
  - COMMAND bit indices (CS=0, WE=1, CAS=2, RAS=3, WREN=4, RDEN=5).
  - The 16-word window size.
- One sub-module, wb_csr_ack_fsm: window decode plus the IDLE/ACK handshake, emitting a one-cycle write-enable, read-enable and offset. It is reused by the other CSR banks.

Test Plan:
- After rst, read offsets 0-6 -> every read returns 0; each ack arrives 1 cycle after stb and is 1 cycle wide; dfi_reset_n=0 and cs_n=1.
- Write CONTROL=0x0C, then 0x0E -> after the second ack, dfi_odt=1, dfi_reset_n=1, dfi_cke=1, dfi_sel=0.
- Write ADDRESS=0x200, BADDRESS=2, COMMAND=0x0F, ISSUE=1 -> exactly one cycle with cs_n=ras_n=cas_n=we_n=0, address=0x200, bank=2; then NOP.
- Write ADDRESS=0x400, COMMAND=0x03, ISSUE=1 -> one cycle with cs_n=0, we_n=0, ras_n=cas_n=1 (ZQCL, A10=1); ISSUE=0 -> no pulse.
- Pulse dfi_rddata_valid with 0xFACECA8C, then read RDDATA -> 0xFACECA8C. Read on the same edge as a capture of 0x12345678 -> returns 0xFACECA8C; the next read returns 0x12345678.
- Write ADDRESS=0xFFFFFFFF with sel=0x1 -> reads 0x000000FF. Access byte address 0x9040 -> no ack for 20 cycles. Assert rst during the ACK cycle -> ack low next cycle and all outputs back at reset values.
